// File: rtl/tile_pingpong_sched.sv
// Job scheduler for the double-buffered tile loader: ping-pong DMA loads overlapped with compute.
// Define TILE_SCHED_PERF_EN to build the DMA/compute stall performance counters.
module tile_pingpong_sched #(
  parameter int unsigned NUM_TILES = 16,
  localparam int unsigned CW = $clog2(NUM_TILES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          job_start,
  output logic          job_busy,
  output logic          job_done,
  output logic          dma_start,
  input  logic          dma_done,
  output logic          wr_ptr,
  output logic          comp_start,
  output logic          comp_buf,
  input  logic          comp_done,
  output logic [1:0]    buf_full,
  output logic [CW-1:0] tiles_loaded,
  output logic [CW-1:0] tiles_computed,
  output logic [31:0]   dma_stall_cycles,
  output logic [31:0]   comp_stall_cycles
);
  localparam logic [CW-1:0] TILES_MAX  = CW'(NUM_TILES);
  localparam logic [CW-1:0] TILES_LAST = CW'(NUM_TILES - 1);

  typedef enum logic {J_IDLE, J_RUN}  job_state_e;
  typedef enum logic {L_IDLE, L_WAIT} load_state_e;
  typedef enum logic {C_IDLE, C_RUN}  comp_state_e;

  job_state_e    job_q, job_d;
  load_state_e   load_q, load_d;
  comp_state_e   comp_q, comp_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    buf_full_q, buf_full_d;
  logic [1:0]    load_view_c;
  logic [CW-1:0] loaded_q, loaded_d;
  logic [CW-1:0] computed_q, computed_d;
  logic [CW-1:0] issued_q, issued_d;
  logic          dma_start_q, dma_start_d;
  logic          comp_start_q, comp_start_d;

  logic run_c, accept_c, dma_ack_c, comp_ack_c, job_done_c;

  assign run_c      = (job_q == J_RUN);
  assign accept_c   = (job_q == J_IDLE) && job_start;
  assign dma_ack_c  = (load_q == L_WAIT) && dma_done;
  assign comp_ack_c = (comp_q == C_RUN) && comp_done;
  assign job_done_c = run_c && comp_ack_c && (computed_q == TILES_LAST);

  // Job, load and compute next-state; load decisions ignore same-cycle frees, compute sees same-cycle fills
  always_comb begin
    job_d        = job_q;
    load_d       = load_q;
    comp_d       = comp_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    buf_full_d   = buf_full_q;
    load_view_c  = buf_full_q;
    loaded_d     = loaded_q;
    computed_d   = computed_q;
    issued_d     = issued_q;
    dma_start_d  = 1'b0;
    comp_start_d = 1'b0;

    if (accept_c) begin
      job_d       = J_RUN;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      buf_full_d  = 2'b00;
      load_view_c = 2'b00;
      loaded_d    = '0;
      computed_d  = '0;
      issued_d    = '0;
    end else if (job_done_c) begin
      job_d = J_IDLE;
    end

    if (dma_ack_c) begin
      buf_full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = ~wr_ptr_q;
      load_d               = L_IDLE;
      if (loaded_q != TILES_MAX) loaded_d = loaded_q + CW'(1);
    end

    if ((run_c || accept_c) && ((load_q == L_IDLE) || dma_ack_c) &&
        (issued_d < TILES_MAX) && !load_view_c[wr_ptr_d]) begin
      dma_start_d = 1'b1;
      load_d      = L_WAIT;
      issued_d    = issued_d + CW'(1);
    end

    if (comp_ack_c) begin
      buf_full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = ~rd_ptr_q;
      comp_d               = C_IDLE;
      if (computed_q != TILES_MAX) computed_d = computed_q + CW'(1);
    end else if (run_c && (comp_q == C_IDLE) && buf_full_d[rd_ptr_q]) begin
      comp_start_d = 1'b1;
      comp_d       = C_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_q        <= J_IDLE;
      load_q       <= L_IDLE;
      comp_q       <= C_IDLE;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_full_q   <= 2'b00;
      loaded_q     <= '0;
      computed_q   <= '0;
      issued_q     <= '0;
      dma_start_q  <= 1'b0;
      comp_start_q <= 1'b0;
    end else begin
      job_q        <= job_d;
      load_q       <= load_d;
      comp_q       <= comp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_full_q   <= buf_full_d;
      loaded_q     <= loaded_d;
      computed_q   <= computed_d;
      issued_q     <= issued_d;
      dma_start_q  <= dma_start_d;
      comp_start_q <= comp_start_d;
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] dma_stall_q, comp_stall_q;
  logic        dma_stall_inc_c, comp_stall_inc_c;

  assign dma_stall_inc_c  = run_c && (load_q == L_IDLE) && (issued_q < TILES_MAX) &&
                            buf_full_q[wr_ptr_q];
  assign comp_stall_inc_c = run_c && (comp_q == C_IDLE) && !buf_full_q[rd_ptr_q];

  // Saturating stall counters, cleared by an accepted job and held between jobs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dma_stall_q  <= 32'd0;
      comp_stall_q <= 32'd0;
    end else if (accept_c) begin
      dma_stall_q  <= 32'd0;
      comp_stall_q <= 32'd0;
    end else begin
      if (dma_stall_inc_c && (dma_stall_q != 32'hFFFF_FFFF))
        dma_stall_q <= dma_stall_q + 32'd1;
      if (comp_stall_inc_c && (comp_stall_q != 32'hFFFF_FFFF))
        comp_stall_q <= comp_stall_q + 32'd1;
    end
  end

  assign dma_stall_cycles  = dma_stall_q;
  assign comp_stall_cycles = comp_stall_q;
`else
  assign dma_stall_cycles  = 32'd0;
  assign comp_stall_cycles = 32'd0;
`endif

  assign job_busy       = run_c;
  assign job_done       = job_done_c;
  assign dma_start      = dma_start_q;
  assign wr_ptr         = wr_ptr_q;
  assign comp_start     = comp_start_q;
  assign comp_buf       = rd_ptr_q;
  assign buf_full       = buf_full_q;
  assign tiles_loaded   = loaded_q;
  assign tiles_computed = computed_q;

endmodule

// File: tb/tb_tile_pingpong_sched.sv
// Bench for tile_pingpong_sched: per-tile latencies feed a timestamp model of every load/compute event.
module tb_tile_pingpong_sched;
  localparam int NT = 4;
  localparam int CW = $clog2(NT + 1);
`ifdef TILE_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, job_start, dma_done, comp_done;
  logic          job_busy, job_done, dma_start, wr_ptr, comp_start, comp_buf;
  logic [1:0]    buf_full;
  logic [CW-1:0] tiles_loaded, tiles_computed;
  logic [31:0]   dma_stall_cycles, comp_stall_cycles;

  tile_pingpong_sched #(.NUM_TILES(NT)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_busy(job_busy),
    .job_done(job_done), .dma_start(dma_start), .dma_done(dma_done), .wr_ptr(wr_ptr),
    .comp_start(comp_start), .comp_buf(comp_buf), .comp_done(comp_done),
    .buf_full(buf_full), .tiles_loaded(tiles_loaded), .tiles_computed(tiles_computed),
    .dma_stall_cycles(dma_stall_cycles), .comp_stall_cycles(comp_stall_cycles)
  );

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0;
  int cur_t = 0, job_id = 0;
  int ld[NT], lc[NT];
  int s_t[NT], dd_t[NT], cs_t[NT], cd_t[NT];
  int exp_dstall = 0, exp_cstall = 0, held_cnt = 0;
  int n_dstarts, n_cstarts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s job%0d t=%0d: got %0d expected %0d", tag, job_id, cur_t, got, exp);
    end
  endtask

  // Event timestamps (cycles after job_start) derived from the scheduling rules
  task automatic build_model();
    int d, c;
    for (int k = 0; k < NT; k++) begin
      d = 0;
      if (k >= 1) d = dd_t[k-1];
      if (k >= 2 && cd_t[k-2] + 1 > d) d = cd_t[k-2] + 1;
      s_t[k]  = d + 1;
      dd_t[k] = s_t[k] + ld[k];
      c = dd_t[k];
      if (k >= 1 && cd_t[k-1] + 1 > c) c = cd_t[k-1] + 1;
      cs_t[k] = c + 1;
      cd_t[k] = cs_t[k] + lc[k];
    end
  endtask

  function automatic int n_loaded(input int t);
    int n = 0;
    for (int k = 0; k < NT; k++) if (dd_t[k] < t) n++;
    return n;
  endfunction
  function automatic int n_computed(input int t);
    int n = 0;
    for (int k = 0; k < NT; k++) if (cd_t[k] < t) n++;
    return n;
  endfunction
  function automatic int n_issued(input int t);
    int n = 0;
    for (int k = 0; k < NT; k++) if (s_t[k] <= t) n++;
    return n;
  endfunction
  function automatic bit load_busy(input int t);
    bit b = 1'b0;
    for (int k = 0; k < NT; k++) if (s_t[k] <= t && t <= dd_t[k]) b = 1'b1;
    return b;
  endfunction
  function automatic bit comp_busy(input int t);
    bit b = 1'b0;
    for (int k = 0; k < NT; k++) if (cs_t[k] <= t && t <= cd_t[k]) b = 1'b1;
    return b;
  endfunction
  function automatic bit is_dstart(input int t);
    bit b = 1'b0;
    for (int k = 0; k < NT; k++) if (s_t[k] == t) b = 1'b1;
    return b;
  endfunction
  function automatic bit is_cstart(input int t);
    bit b = 1'b0;
    for (int k = 0; k < NT; k++) if (cs_t[k] == t) b = 1'b1;
    return b;
  endfunction
  function automatic bit full_at(input int b, input int t);
    bit f = 1'b0;
    for (int k = 0; k < NT; k++) if ((k % 2) == b && dd_t[k] < t && t <= cd_t[k]) f = 1'b1;
    return f;
  endfunction

  task automatic check_cycle(input int t);
    int el, ec;
    el = (t == 0) ? held_cnt : n_loaded(t);
    ec = (t == 0) ? held_cnt : n_computed(t);
    check("job_busy", 32'(job_busy), 32'(t >= 1 && t <= cd_t[NT-1]));
    check("job_done", 32'(job_done), 32'(t == cd_t[NT-1]));
    check("dma_start", 32'(dma_start), 32'(is_dstart(t)));
    check("comp_start", 32'(comp_start), 32'(is_cstart(t)));
    check("wr_ptr", 32'(wr_ptr), 32'(el % 2));
    check("comp_buf", 32'(comp_buf), 32'(ec % 2));
    check("buf_full", 32'(buf_full), 32'({full_at(1, t), full_at(0, t)}));
    check("tiles_loaded", 32'(tiles_loaded), 32'(el));
    check("tiles_computed", 32'(tiles_computed), 32'(ec));
    check("dma_stall", dma_stall_cycles, PERF ? 32'(exp_dstall) : 32'd0);
    check("comp_stall", comp_stall_cycles, PERF ? 32'(exp_cstall) : 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(job_busy), 32'd0);
    check({tag, "_done"}, 32'(job_done), 32'd0);
    check({tag, "_dma_start"}, 32'(dma_start), 32'd0);
    check({tag, "_comp_start"}, 32'(comp_start), 32'd0);
    check({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
    check({tag, "_comp_buf"}, 32'(comp_buf), 32'd0);
    check({tag, "_buf_full"}, 32'(buf_full), 32'd0);
    check({tag, "_loaded"}, 32'(tiles_loaded), 32'd0);
    check({tag, "_computed"}, 32'(tiles_computed), 32'd0);
    check({tag, "_dma_stall"}, dma_stall_cycles, 32'd0);
    check({tag, "_comp_stall"}, comp_stall_cycles, 32'd0);
  endtask

  // One job, cycle by cycle; optional spurious pulses, stray job_start, or a mid-job reset
  task automatic run_job(input bit noise, input bit abort);
    int dd_due, cd_due, t_end, inj_t, abort_t;
    bit stop;
    build_model();
    job_id++;
    t_end   = cd_t[NT-1] + 4;
    abort_t = abort ? dd_t[1] + 1 : -1;
    inj_t   = noise ? int'($urandom_range(cd_t[NT-1], 1)) : -1;
    dd_due = -1; cd_due = -1; n_dstarts = 0; n_cstarts = 0; stop = 1'b0;
    for (int t = 0; t <= t_end && !stop; t++) begin
      cur_t     = t;
      rst_n     = (t != abort_t);
      job_start = (t == 0) || (t == inj_t);
      dma_done  = (t == dd_due);
      comp_done = (t == cd_due);
      if (noise && !load_busy(t) && $urandom_range(3, 0) == 0) dma_done = 1'b1;
      if (noise && !comp_busy(t) && $urandom_range(3, 0) == 0) comp_done = 1'b1;
      if (t == abort_t) begin
        dma_done = 1'b0; comp_done = 1'b0;
      end
      @(negedge clk);
      if (abort && t == abort_t + 1) begin
        check_zero("rst_mid");
        held_cnt = 0; exp_dstall = 0; exp_cstall = 0;
        stop = 1'b1;
      end else begin
        if (t == abort_t) check("abort_loaded", 32'(tiles_loaded), 32'd2);
        check_cycle(t);
        if (t == 0) begin
          exp_dstall = 0; exp_cstall = 0;
        end
        if (t >= 1 && t <= cd_t[NT-1]) begin
          if (!load_busy(t) && n_issued(t) < NT && full_at(n_loaded(t) % 2, t)) exp_dstall++;
          if (!comp_busy(t) && !full_at(n_computed(t) % 2, t)) exp_cstall++;
        end
        if (dma_start) begin
          dd_due = t + ((n_dstarts < NT) ? ld[n_dstarts] : 1);
          n_dstarts++;
        end
        if (comp_start) begin
          cd_due = t + ((n_cstarts < NT) ? lc[n_cstarts] : 1);
          n_cstarts++;
        end
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1; job_start = 1'b0; dma_done = 1'b0; comp_done = 1'b0;
    if (!abort) begin
      held_cnt = NT;
      check("n_dma_start", 32'(n_dstarts), 32'(NT));
      check("n_comp_start", 32'(n_cstarts), 32'(NT));
    end
  endtask

  task automatic set_lat(input int dl, input int cl);
    for (int k = 0; k < NT; k++) begin
      ld[k] = dl; lc[k] = cl;
    end
  endtask

  initial begin
    rst_n = 1'b0; job_start = 1'b0; dma_done = 1'b0; comp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    set_lat(3, 10);
    run_job(1'b0, 1'b0);
    check("comp_stall_fill", comp_stall_cycles, PERF ? 32'd4 : 32'd0);

    set_lat(2, 50);
    run_job(1'b0, 1'b0);

    ld[0] = 3; ld[1] = 5; ld[2] = 3; ld[3] = 3;
    lc[0] = 5; lc[1] = 5; lc[2] = 5; lc[3] = 5;
    run_job(1'b0, 1'b0);

    set_lat(3, 10);
    run_job(1'b1, 1'b0);
    run_job(1'b0, 1'b1);
    run_job(1'b0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < NT; k++) begin
        ld[k] = int'($urandom_range(8, 1));
        lc[k] = int'($urandom_range(20, 1));
      end
      run_job(1'b1, (j == 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
